// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module   : multicycle_control_pkg
// Purpose  : Shared encodings for the multicycle control unit: RV32 opcode,
//            funct3 and funct7 values, ALU operation codes, FSM state encoding
//            and the instruction class used between decoder and FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

    // Major opcodes
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] c_F3_ADD_SUB = 3'b000;
    localparam logic [2:0] c_F3_SLL     = 3'b001;
    localparam logic [2:0] c_F3_XOR     = 3'b100;
    localparam logic [2:0] c_F3_SRL     = 3'b101;
    localparam logic [2:0] c_F3_OR      = 3'b110;
    localparam logic [2:0] c_F3_AND     = 3'b111;
    localparam logic [2:0] c_F3_ADDI    = 3'b000;
    localparam logic [2:0] c_F3_WORD    = 3'b010;
    localparam logic [2:0] c_F3_BEQ     = 3'b000;
    localparam logic [2:0] c_F3_BNE     = 3'b001;

    // funct7 values
    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    // ALU operation codes
    localparam int         c_ALU_CODE_W = 3;
    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_XOR = 3'd4;
    localparam logic [2:0] c_ALU_SLL = 3'd5;
    localparam logic [2:0] c_ALU_SRL = 3'd6;

    // FSM state encoding (visible on the state output)
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Instruction classes that steer the FSM after DECODE
    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_LOAD  = 3'd1,
        CLS_STORE = 3'd2,
        CLS_BEQ   = 3'd3,
        CLS_BNE   = 3'd4
    } iclass_t;

    // Destination register field
    function automatic logic [4:0] rd_of(input logic [31:0] i_word);
        return i_word[11:7];
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_decode.sv
// ============================================================================
// Module   : control_decode
// Purpose  : Combinational classifier for the instruction register. Produces
//            the instruction class, ALU op, ALU operand-B select, a flag for
//            a non-x0 destination, and a legality flag.
//            Optional build macro: MULTICYCLE_CONTROL_SHIFT_EN enables sll/srl;
//            without it those encodings are reported illegal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_decode
    import multicycle_control_pkg::*;
(
    input  logic [31:0] i_instr,
    output iclass_t     o_class,
    output logic [2:0]  o_alu_op,
    output logic        o_alu_src,
    output logic        o_rd_nz,
    output logic        o_legal
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_unused;

    assign w_op     = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign o_rd_nz  = (rd_of(i_instr) != 5'd0);
    // Register-source and immediate fields are a datapath concern.
    assign w_unused = ^i_instr[24:15];

    // Classify opcode/funct3/funct7 into class, ALU op and legality
    always_comb begin
        o_class   = CLS_ALU;
        o_alu_op  = c_ALU_ADD;
        o_alu_src = 1'b0;
        o_legal   = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                if (w_f7 == c_F7_BASE) begin
                    case (w_f3)
                        c_F3_ADD_SUB: begin o_legal = 1'b1; o_alu_op = c_ALU_ADD; end
                        c_F3_AND:     begin o_legal = 1'b1; o_alu_op = c_ALU_AND; end
                        c_F3_OR:      begin o_legal = 1'b1; o_alu_op = c_ALU_OR;  end
                        c_F3_XOR:     begin o_legal = 1'b1; o_alu_op = c_ALU_XOR; end
                        c_F3_SLL: begin
`ifdef MULTICYCLE_CONTROL_SHIFT_EN
                            o_legal  = 1'b1;
                            o_alu_op = c_ALU_SLL;
`else
                            o_legal  = 1'b0;
`endif
                        end
                        c_F3_SRL: begin
`ifdef MULTICYCLE_CONTROL_SHIFT_EN
                            o_legal  = 1'b1;
                            o_alu_op = c_ALU_SRL;
`else
                            o_legal  = 1'b0;
`endif
                        end
                        default: o_legal = 1'b0;
                    endcase
                end else if ((w_f7 == c_F7_ALT) && (w_f3 == c_F3_ADD_SUB)) begin
                    o_legal  = 1'b1;
                    o_alu_op = c_ALU_SUB;
                end
            end
            c_OP_IMM: begin
                // Only addi; the upper bits are immediate, not funct7.
                if (w_f3 == c_F3_ADDI) begin
                    o_legal   = 1'b1;
                    o_alu_src = 1'b1;
                end
            end
            c_OP_LOAD: begin
                if (w_f3 == c_F3_WORD) begin
                    o_legal   = 1'b1;
                    o_class   = CLS_LOAD;
                    o_alu_src = 1'b1;
                end
            end
            c_OP_STORE: begin
                if (w_f3 == c_F3_WORD) begin
                    o_legal   = 1'b1;
                    o_class   = CLS_STORE;
                    o_alu_src = 1'b1;
                end
            end
            c_OP_BRANCH: begin
                if (w_f3 == c_F3_BEQ) begin
                    o_legal  = 1'b1;
                    o_class  = CLS_BEQ;
                    o_alu_op = c_ALU_SUB;
                end else if (w_f3 == c_F3_BNE) begin
                    o_legal  = 1'b1;
                    o_class  = CLS_BNE;
                    o_alu_op = c_ALU_SUB;
                end
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multicycle RV32 subset control FSM (FETCH/DECODE/EXEC/MEM/WB/
//            HALT) with bounded memory waits and sticky illegal/timeout flags.
//            Optional build macro: MULTICYCLE_CONTROL_SHIFT_EN (sll/srl).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int ALU_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             ALUSrc,
    output logic [ALU_W-1:0] ALUCtrl,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout
);

    // Last wait-counter value before the bound is reached
    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_wait;
    iclass_t    r_cls;
    logic [2:0] r_alu;
    logic       r_alu_src;
    logic       r_rd_nz;
    logic       r_illegal;
    logic       r_timeout;

    iclass_t    w_cls;
    logic [2:0] w_alu_op;
    logic       w_alu_src;
    logic       w_rd_nz;
    logic       w_legal;
    logic       w_taken;

    control_decode u_decode (
        .i_instr   (instr),
        .o_class   (w_cls),
        .o_alu_op  (w_alu_op),
        .o_alu_src (w_alu_src),
        .o_rd_nz   (w_rd_nz),
        .o_legal   (w_legal)
    );

    // FSM: state, bounded wait counter, latched decode and sticky fault flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_wait    <= 8'd0;
            r_cls     <= CLS_ALU;
            r_alu     <= c_ALU_ADD;
            r_alu_src <= 1'b0;
            r_rd_nz   <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    // A ready on the final counted cycle still completes.
                    if (mem_ready) begin
                        r_state <= ST_DECODE;
                        r_wait  <= 8'd0;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_state   <= ST_HALT;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_DECODE: begin
                    // Latch the classification so EXEC..WB do not depend
                    // on the instruction register staying stable.
                    r_cls     <= w_cls;
                    r_alu     <= w_alu_op;
                    r_alu_src <= w_alu_src;
                    r_rd_nz   <= w_rd_nz;
                    if (w_legal) begin
                        r_state <= ST_EXEC;
                    end else begin
                        r_state   <= ST_HALT;
                        r_illegal <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_wait <= 8'd0;
                    case (r_cls)
                        CLS_LOAD, CLS_STORE: r_state <= ST_MEM;
                        CLS_BEQ, CLS_BNE:    r_state <= ST_FETCH;
                        default:             r_state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        r_state <= (r_cls == CLS_STORE) ? ST_FETCH : ST_WB;
                        r_wait  <= 8'd0;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_state   <= ST_HALT;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_WB: begin
                    r_state <= ST_FETCH;
                    r_wait  <= 8'd0;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_HALT;
            endcase
        end
    end

    // Branch decision follows the live zero flag within EXEC
    assign w_taken = ((r_cls == CLS_BEQ) && zero) || ((r_cls == CLS_BNE) && !zero);

    // Control strobes decoded from the current state; inactive ones stay 0
    always_comb begin
        MemReq   = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUSrc   = 1'b0;
        ALUCtrl  = '0;
        case (r_state)
            ST_FETCH: begin
                MemReq = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            ST_EXEC: begin
                ALUCtrl = ALU_W'(r_alu);
                ALUSrc  = r_alu_src;
                if ((r_cls == CLS_BEQ) || (r_cls == CLS_BNE)) begin
                    PCWrite = w_taken;
                    PCSrc   = w_taken;
                end
            end
            ST_MEM: begin
                MemReq   = 1'b1;
                MemWrite = (r_cls == CLS_STORE);
            end
            ST_WB: begin
                RegWrite = r_rd_nz;
                MemToReg = (r_cls == CLS_LOAD);
            end
            default: ;
        endcase
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign timeout = r_timeout;

endmodule

`default_nettype wire
